// File: rtl/store_buffer_coalescing_if.sv
// Store-buffer bus bundle: store-unit push/commit, load lookup and the D$ store port.
interface store_buffer_coalescing_if #(
    parameter int unsigned PLEN = 56,
    parameter int unsigned XLEN = 64
);
    localparam int unsigned BeW    = XLEN / 8;
    localparam int unsigned IndexW = 12;
    localparam int unsigned TagW   = PLEN - IndexW;
    localparam int unsigned IdW    = 4;

    logic              flush_i;
    logic              stall_st_pending_i;
    logic              valid_i;
    logic              valid_without_flush_i;
    logic [PLEN-1:0]   paddr_i;
    logic [XLEN-1:0]   data_i;
    logic [BeW-1:0]    be_i;
    logic [1:0]        data_size_i;
    logic              commit_i;
    logic              ready_o;
    logic              commit_ready_o;
    logic              no_st_pending_o;
    logic              store_buffer_empty_o;
    logic [11:0]       page_offset_i;
    logic              page_offset_matches_o;
    logic [PLEN-1:0]   fwd_paddr_i;
    logic [BeW-1:0]    fwd_be_i;
    logic              fwd_valid_i;
    logic              fwd_hit_o;
    logic [XLEN-1:0]   fwd_data_o;
    // D$ store port
    logic              rsp_data_gnt_i;
    logic              req_data_req_o;
    logic              req_data_we_o;
    logic              req_kill_req_o;
    logic              req_tag_valid_o;
    logic [IdW-1:0]    req_data_id_o;
    logic [IndexW-1:0] req_address_index_o;
    logic [TagW-1:0]   req_address_tag_o;
    logic [XLEN-1:0]   req_data_wdata_o;
    logic [BeW-1:0]    req_data_be_o;
    logic [1:0]        req_data_size_o;

    modport slave (
        input  flush_i, stall_st_pending_i, valid_i, valid_without_flush_i, paddr_i,
               data_i, be_i, data_size_i, commit_i, page_offset_i, fwd_paddr_i,
               fwd_be_i, fwd_valid_i, rsp_data_gnt_i,
        output ready_o, commit_ready_o, no_st_pending_o, store_buffer_empty_o,
               page_offset_matches_o, fwd_hit_o, fwd_data_o, req_data_req_o,
               req_data_we_o, req_kill_req_o, req_tag_valid_o, req_data_id_o,
               req_address_index_o, req_address_tag_o, req_data_wdata_o,
               req_data_be_o, req_data_size_o
    );

    modport master (
        output flush_i, stall_st_pending_i, valid_i, valid_without_flush_i, paddr_i,
               data_i, be_i, data_size_i, commit_i, page_offset_i, fwd_paddr_i,
               fwd_be_i, fwd_valid_i, rsp_data_gnt_i,
        input  ready_o, commit_ready_o, no_st_pending_o, store_buffer_empty_o,
               page_offset_matches_o, fwd_hit_o, fwd_data_o, req_data_req_o,
               req_data_we_o, req_kill_req_o, req_tag_valid_o, req_data_id_o,
               req_address_index_o, req_address_tag_o, req_data_wdata_o,
               req_data_be_o, req_data_size_o
    );
endinterface

// File: rtl/store_buffer_coalescing.sv
// Speculative + commit store queues with same-doubleword coalescing on commit
// and youngest-first store-to-load forwarding.
module store_buffer_coalescing #(
    parameter int unsigned PLEN        = 56,
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DepthSpec   = 4,
    parameter int unsigned DepthCommit = 8,
    parameter bit          CoalesceEn  = 1'b1,
    parameter bit          ForwardEn   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    store_buffer_coalescing_if.slave sb
);
    localparam int unsigned BeW      = XLEN / 8;
    localparam int unsigned IndexW   = 12;
    localparam int unsigned SpecPtrW = $clog2(DepthSpec);
    localparam int unsigned SpecCntW = SpecPtrW + 1;
    localparam int unsigned CmtPtrW  = $clog2(DepthCommit);
    localparam int unsigned CmtCntW  = CmtPtrW + 1;

    typedef struct packed {
        logic [PLEN-1:0] address;
        logic [XLEN-1:0] data;
        logic [BeW-1:0]  be;
        logic [1:0]      size;
        logic            valid;
    } entry_t;

    entry_t              spec_q [DepthSpec];
    entry_t              spec_d [DepthSpec];
    entry_t              cmt_q  [DepthCommit];
    entry_t              cmt_d  [DepthCommit];
    logic [SpecPtrW-1:0] spec_rptr_q, spec_rptr_d, spec_wptr_q, spec_wptr_d;
    logic [SpecCntW-1:0] spec_cnt_q, spec_cnt_d;
    logic [CmtPtrW-1:0]  cmt_rptr_q, cmt_rptr_d, cmt_wptr_q, cmt_wptr_d;
    logic [CmtCntW-1:0]  cmt_cnt_q, cmt_cnt_d;

    entry_t              spec_head;
    entry_t              cmt_head;
    logic [CmtPtrW-1:0]  cmt_tail_ptr;
    logic                coalesce, append, data_req, grant;
    logic                fwd_found;
    logic [XLEN-1:0]     fwd_data_sel;
    logic [BeW-1:0]      fwd_be_sel;
    logic                page_match;
    logic                unused_low_bits;

    assign spec_head    = spec_q[spec_rptr_q];
    assign cmt_head     = cmt_q[cmt_rptr_q];
    assign cmt_tail_ptr = cmt_wptr_q - CmtPtrW'(1);

    // Merge only into a tail that is not the entry the D$ may be consuming.
    assign coalesce = CoalesceEn && sb.commit_i && (cmt_cnt_q != '0)
                   && cmt_q[cmt_tail_ptr].valid && (cmt_tail_ptr != cmt_rptr_q)
                   && (cmt_q[cmt_tail_ptr].address[PLEN-1:3] == spec_head.address[PLEN-1:3]);
    assign append   = sb.commit_i && !coalesce;
    assign data_req = cmt_head.valid && !sb.stall_st_pending_i;
    assign grant    = data_req && sb.rsp_data_gnt_i;

    // Speculative queue next state
    always_comb begin
        spec_d      = spec_q;
        spec_rptr_d = spec_rptr_q;
        spec_wptr_d = spec_wptr_q;
        spec_cnt_d  = spec_cnt_q;
        if (sb.flush_i) begin
            for (int i = 0; i < int'(DepthSpec); i++) spec_d[i].valid = 1'b0;
            spec_wptr_d = spec_rptr_q;
            spec_cnt_d  = '0;
        end else begin
            if (sb.commit_i) begin
                spec_d[spec_rptr_q].valid = 1'b0;
                spec_rptr_d               = spec_rptr_q + SpecPtrW'(1);
            end
            if (sb.valid_i) begin
                spec_d[spec_wptr_q] = '{address: sb.paddr_i, data: sb.data_i, be: sb.be_i,
                                        size: sb.data_size_i, valid: 1'b1};
                spec_wptr_d         = spec_wptr_q + SpecPtrW'(1);
            end
            spec_cnt_d = spec_cnt_q + SpecCntW'(sb.valid_i) - SpecCntW'(sb.commit_i);
        end
    end

    // Commit queue next state: drain head, then coalesce into tail or append
    always_comb begin
        cmt_d      = cmt_q;
        cmt_rptr_d = cmt_rptr_q;
        cmt_wptr_d = cmt_wptr_q;
        if (grant) begin
            cmt_d[cmt_rptr_q].valid = 1'b0;
            cmt_rptr_d              = cmt_rptr_q + CmtPtrW'(1);
        end
        if (coalesce) begin
            for (int b = 0; b < int'(BeW); b++) begin
                if (spec_head.be[b]) cmt_d[cmt_tail_ptr].data[8*b +: 8] = spec_head.data[8*b +: 8];
            end
            cmt_d[cmt_tail_ptr].be           = cmt_q[cmt_tail_ptr].be | spec_head.be;
            cmt_d[cmt_tail_ptr].size         = 2'b11;
            cmt_d[cmt_tail_ptr].address[2:0] = 3'b000;
        end else if (append) begin
            cmt_d[cmt_wptr_q]       = spec_head;
            cmt_d[cmt_wptr_q].valid = 1'b1;
            cmt_wptr_d              = cmt_wptr_q + CmtPtrW'(1);
        end
        cmt_cnt_d = cmt_cnt_q + CmtCntW'(append) - CmtCntW'(grant);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DepthSpec); i++) spec_q[i] <= '0;
            for (int i = 0; i < int'(DepthCommit); i++) cmt_q[i] <= '0;
            spec_rptr_q <= '0;
            spec_wptr_q <= '0;
            spec_cnt_q  <= '0;
            cmt_rptr_q  <= '0;
            cmt_wptr_q  <= '0;
            cmt_cnt_q   <= '0;
        end else begin
            spec_q      <= spec_d;
            cmt_q       <= cmt_d;
            spec_rptr_q <= spec_rptr_d;
            spec_wptr_q <= spec_wptr_d;
            spec_cnt_q  <= spec_cnt_d;
            cmt_rptr_q  <= cmt_rptr_d;
            cmt_wptr_q  <= cmt_wptr_d;
            cmt_cnt_q   <= cmt_cnt_d;
        end
    end

    // Oldest-to-youngest walk so the last hit (youngest, spec after commit) wins
    always_comb begin
        fwd_found    = 1'b0;
        fwd_data_sel = '0;
        fwd_be_sel   = '0;
        for (int i = 0; i < int'(DepthCommit); i++) begin
            if (cmt_q[cmt_rptr_q + CmtPtrW'(i)].valid
                && (cmt_q[cmt_rptr_q + CmtPtrW'(i)].address[PLEN-1:3] == sb.fwd_paddr_i[PLEN-1:3])) begin
                fwd_found    = 1'b1;
                fwd_data_sel = cmt_q[cmt_rptr_q + CmtPtrW'(i)].data;
                fwd_be_sel   = cmt_q[cmt_rptr_q + CmtPtrW'(i)].be;
            end
        end
        for (int i = 0; i < int'(DepthSpec); i++) begin
            if (spec_q[spec_rptr_q + SpecPtrW'(i)].valid
                && (spec_q[spec_rptr_q + SpecPtrW'(i)].address[PLEN-1:3] == sb.fwd_paddr_i[PLEN-1:3])) begin
                fwd_found    = 1'b1;
                fwd_data_sel = spec_q[spec_rptr_q + SpecPtrW'(i)].data;
                fwd_be_sel   = spec_q[spec_rptr_q + SpecPtrW'(i)].be;
            end
        end
    end

    always_comb begin
        page_match = sb.valid_without_flush_i && (sb.paddr_i[11:3] == sb.page_offset_i[11:3]);
        for (int i = 0; i < int'(DepthSpec); i++) begin
            if (spec_q[i].valid && (spec_q[i].address[11:3] == sb.page_offset_i[11:3])) page_match = 1'b1;
        end
        for (int i = 0; i < int'(DepthCommit); i++) begin
            if (cmt_q[i].valid && (cmt_q[i].address[11:3] == sb.page_offset_i[11:3])) page_match = 1'b1;
        end
    end

    assign sb.ready_o               = (spec_cnt_q < SpecCntW'(DepthSpec - 1)) || sb.commit_i;
    assign sb.commit_ready_o        = cmt_cnt_q < CmtCntW'(DepthCommit);
    assign sb.no_st_pending_o       = (cmt_cnt_q == '0);
    assign sb.store_buffer_empty_o  = (spec_cnt_q == '0) && (cmt_cnt_q == '0);
    assign sb.page_offset_matches_o = page_match;
    assign sb.fwd_hit_o             = ForwardEn && sb.fwd_valid_i && fwd_found
                                   && ((fwd_be_sel & sb.fwd_be_i) == sb.fwd_be_i);
    assign sb.fwd_data_o            = sb.fwd_hit_o ? fwd_data_sel : '0;

    assign sb.req_data_req_o      = data_req;
    assign sb.req_data_we_o       = 1'b1;
    assign sb.req_kill_req_o      = 1'b0;
    assign sb.req_tag_valid_o     = 1'b0;
    assign sb.req_data_id_o       = '0;
    assign sb.req_address_index_o = cmt_head.address[IndexW-1:0];
    assign sb.req_address_tag_o   = cmt_head.address[PLEN-1:IndexW];
    assign sb.req_data_wdata_o    = cmt_head.data;
    assign sb.req_data_be_o       = cmt_head.be;
    assign sb.req_data_size_o     = cmt_head.size;

    assign unused_low_bits = ^{sb.page_offset_i[2:0], sb.fwd_paddr_i[2:0]};

    // A flushed pipeline cannot also retire a store in the same cycle.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(sb.flush_i && sb.commit_i))
        else $error("flush_i and commit_i asserted together");
endmodule

// File: tb/tb_store_buffer_coalescing.sv
// Scoreboard bench: expected D$ requests are queued at commit and checked as they drain.
module tb_store_buffer_coalescing;
    localparam int unsigned PLEN = 56;
    localparam int unsigned XLEN = 64;
    localparam int unsigned BeW  = XLEN / 8;

    typedef struct {
        logic [PLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [BeW-1:0]  be;
        logic [1:0]      size;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    store_buffer_coalescing_if #(.PLEN(PLEN), .XLEN(XLEN)) sb ();

    store_buffer_coalescing #(
        .PLEN(PLEN), .XLEN(XLEN), .DepthSpec(4), .DepthCommit(8),
        .CoalesceEn(1'b1), .ForwardEn(1'b1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .sb    (sb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sb.flush_i = 1'b0; sb.stall_st_pending_i = 1'b0; sb.valid_i = 1'b0;
        sb.valid_without_flush_i = 1'b0; sb.paddr_i = '0; sb.data_i = '0; sb.be_i = '0;
        sb.data_size_i = '0; sb.commit_i = 1'b0; sb.page_offset_i = '0; sb.fwd_paddr_i = '0;
        sb.fwd_be_i = '0; sb.fwd_valid_i = 1'b0; sb.rsp_data_gnt_i = 1'b0;
    endtask

    task automatic push(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                        input logic [BeW-1:0] be, input logic [1:0] sz);
        sb.valid_i = 1'b1; sb.paddr_i = a; sb.data_i = d; sb.be_i = be; sb.data_size_i = sz;
        tick();
        sb.valid_i = 1'b0;
    endtask

    task automatic commit_one();
        sb.commit_i = 1'b1;
        tick();
        sb.commit_i = 1'b0;
    endtask

    task automatic expect_req(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                              input logic [BeW-1:0] be, input logic [1:0] sz);
        exp_t e;
        e.addr = a; e.data = d; e.be = be; e.size = sz;
        exp_q.push_back(e);
    endtask

    // Grant every request and compare it with the scoreboard head
    task automatic drain(input int n, output int cycles);
        int   got;
        exp_t e;
        logic [PLEN-1:0] act_addr;
        got = 0; cycles = 0;
        sb.stall_st_pending_i = 1'b0;
        sb.rsp_data_gnt_i     = 1'b1;
        #1;
        while (got < n && cycles < n + 16) begin
            if (sb.req_data_req_o) begin
                n_checks++;
                act_addr = {sb.req_address_tag_o, sb.req_address_index_o};
                if (exp_q.size() == 0) begin
                    $display("FAIL drain_unexpected: got addr=%h with no expected request", act_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (act_addr !== e.addr || sb.req_data_wdata_o !== e.data || sb.req_data_be_o !== e.be
                        || sb.req_data_size_o !== e.size || sb.req_data_we_o !== 1'b1
                        || sb.req_kill_req_o !== 1'b0 || sb.req_tag_valid_o !== 1'b0 || sb.req_data_id_o !== '0)
                        $display("FAIL drain_req: got addr=%h data=%h be=%h size=%0d we=%b, expected addr=%h data=%h be=%h size=%0d we=1",
                                 act_addr, sb.req_data_wdata_o, sb.req_data_be_o, sb.req_data_size_o,
                                 sb.req_data_we_o, e.addr, e.data, e.be, e.size);
                    else n_pass++;
                end
                got++;
            end
            cycles++;
            tick();
        end
        sb.rsp_data_gnt_i = 1'b0;
        n_checks++;
        if (got !== n) $display("FAIL drain_count: got %0d requests, expected %0d", got, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (sb.ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", sb.ready_o); else n_pass++;
        n_checks++; if (sb.commit_ready_o !== 1'b1) $display("FAIL reset_commit_ready: got %b expected 1", sb.commit_ready_o); else n_pass++;
        n_checks++; if (sb.no_st_pending_o !== 1'b1) $display("FAIL reset_no_st_pending: got %b expected 1", sb.no_st_pending_o); else n_pass++;
        n_checks++; if (sb.store_buffer_empty_o !== 1'b1) $display("FAIL reset_empty: got %b expected 1", sb.store_buffer_empty_o); else n_pass++;
        n_checks++; if (sb.req_data_req_o !== 1'b0) $display("FAIL reset_data_req: got %b expected 0", sb.req_data_req_o); else n_pass++;
        n_checks++; if (sb.fwd_hit_o !== 1'b0) $display("FAIL reset_fwd_hit: got %b expected 0", sb.fwd_hit_o); else n_pass++;
        n_checks++; if (sb.page_offset_matches_o !== 1'b0) $display("FAIL reset_page_match: got %b expected 0", sb.page_offset_matches_o); else n_pass++;
    endtask

    task automatic test_push_commit_drain();
        int cyc;
        push(56'h80001000, 64'h11, 8'h01, 2'd0);
        sb.page_offset_i = 12'h000;
        #1;
        n_checks++; if (sb.store_buffer_empty_o !== 1'b0) $display("FAIL push_empty: got %b expected 0", sb.store_buffer_empty_o); else n_pass++;
        n_checks++; if (sb.no_st_pending_o !== 1'b1) $display("FAIL push_no_st_pending: got %b expected 1", sb.no_st_pending_o); else n_pass++;
        n_checks++; if (sb.page_offset_matches_o !== 1'b1) $display("FAIL push_page_match: got %b expected 1", sb.page_offset_matches_o); else n_pass++;
        sb.page_offset_i = 12'h008;
        #1;
        n_checks++; if (sb.page_offset_matches_o !== 1'b0) $display("FAIL push_page_nomatch: got %b expected 0", sb.page_offset_matches_o); else n_pass++;
        expect_req(56'h80001000, 64'h11, 8'h01, 2'd0);
        commit_one();
        #1;
        n_checks++; if (sb.req_data_req_o !== 1'b1) $display("FAIL commit_to_req: got %b expected 1", sb.req_data_req_o); else n_pass++;
        drain(1, cyc);
        #1;
        n_checks++; if (sb.no_st_pending_o !== 1'b1) $display("FAIL drain_no_st_pending: got %b expected 1", sb.no_st_pending_o); else n_pass++;
        n_checks++; if (sb.store_buffer_empty_o !== 1'b1) $display("FAIL drain_empty: got %b expected 1", sb.store_buffer_empty_o); else n_pass++;
    endtask

    task automatic test_coalesce();
        int cyc;
        sb.stall_st_pending_i = 1'b1;
        push(56'h80001000, 64'h1, 8'hFF, 2'd3);
        push(56'h80001008, 64'hAAAAAAAA, 8'h0F, 2'd2);
        push(56'h8000100C, 64'hBBBBBBBB00000000, 8'hF0, 2'd2);
        commit_one(); commit_one(); commit_one();
        expect_req(56'h80001000, 64'h1, 8'hFF, 2'd3);
        expect_req(56'h80001008, 64'hBBBBBBBBAAAAAAAA, 8'hFF, 2'd3);
        sb.fwd_paddr_i = 56'h80001008; sb.fwd_be_i = 8'hFF; sb.fwd_valid_i = 1'b1;
        #1;
        n_checks++; if (sb.fwd_hit_o !== 1'b1 || sb.fwd_data_o !== 64'hBBBBBBBBAAAAAAAA)
            $display("FAIL coalesce_fwd: got hit=%b data=%h expected hit=1 data=bbbbbbbbaaaaaaaa", sb.fwd_hit_o, sb.fwd_data_o);
        else n_pass++;
        sb.fwd_valid_i = 1'b0;
        drain(2, cyc);
        #1;
        n_checks++; if (sb.no_st_pending_o !== 1'b1) $display("FAIL coalesce_count: no_st_pending got %b expected 1", sb.no_st_pending_o); else n_pass++;
    endtask

    task automatic test_forwarding();
        int cyc;
        sb.stall_st_pending_i = 1'b1;
        push(56'h80002000, 64'h0123456789ABCDEF, 8'hFF, 2'd3);
        sb.fwd_paddr_i = 56'h80002000; sb.fwd_be_i = 8'h0F; sb.fwd_valid_i = 1'b1;
        #1;
        n_checks++; if (sb.fwd_hit_o !== 1'b1 || sb.fwd_data_o !== 64'h0123456789ABCDEF)
            $display("FAIL fwd_full_cover: got hit=%b data=%h expected hit=1 data=0123456789abcdef", sb.fwd_hit_o, sb.fwd_data_o);
        else n_pass++;
        sb.fwd_paddr_i = 56'h80002008; sb.fwd_be_i = 8'h01;
        #1;
        n_checks++; if (sb.fwd_hit_o !== 1'b0 || sb.fwd_data_o !== 64'h0)
            $display("FAIL fwd_no_match: got hit=%b data=%h expected hit=0 data=0", sb.fwd_hit_o, sb.fwd_data_o);
        else n_pass++;
        push(56'h80002010, 64'hBEEF, 8'h03, 2'd1);
        sb.fwd_paddr_i = 56'h80002010; sb.fwd_be_i = 8'h0F;
        #1;
        n_checks++; if (sb.fwd_hit_o !== 1'b0 || sb.fwd_data_o !== 64'h0)
            $display("FAIL fwd_partial: got hit=%b data=%h expected hit=0 data=0", sb.fwd_hit_o, sb.fwd_data_o);
        else n_pass++;
        sb.fwd_be_i = 8'h03;
        #1;
        n_checks++; if (sb.fwd_hit_o !== 1'b1 || sb.fwd_data_o !== 64'hBEEF)
            $display("FAIL fwd_exact_cover: got hit=%b data=%h expected hit=1 data=beef", sb.fwd_hit_o, sb.fwd_data_o);
        else n_pass++;
        sb.fwd_valid_i = 1'b0;
        #1;
        n_checks++; if (sb.fwd_hit_o !== 1'b0) $display("FAIL fwd_not_valid: got hit=%b expected 0", sb.fwd_hit_o); else n_pass++;
        commit_one(); commit_one();
        expect_req(56'h80002000, 64'h0123456789ABCDEF, 8'hFF, 2'd3);
        expect_req(56'h80002010, 64'hBEEF, 8'h03, 2'd1);
        drain(2, cyc);
    endtask

    task automatic test_youngest();
        int cyc;
        sb.stall_st_pending_i = 1'b1;
        push(56'h80003000, 64'h1, 8'hFF, 2'd3);
        commit_one();
        push(56'h80003000, 64'h2, 8'hFF, 2'd3);
        sb.fwd_paddr_i = 56'h80003000; sb.fwd_be_i = 8'hFF; sb.fwd_valid_i = 1'b1;
        #1;
        n_checks++; if (sb.fwd_hit_o !== 1'b1 || sb.fwd_data_o !== 64'h2)
            $display("FAIL youngest_spec: got hit=%b data=%h expected hit=1 data=2", sb.fwd_hit_o, sb.fwd_data_o);
        else n_pass++;
        commit_one();
        #1;
        n_checks++; if (sb.fwd_hit_o !== 1'b1 || sb.fwd_data_o !== 64'h2)
            $display("FAIL youngest_commit: got hit=%b data=%h expected hit=1 data=2", sb.fwd_hit_o, sb.fwd_data_o);
        else n_pass++;
        sb.fwd_valid_i = 1'b0;
        expect_req(56'h80003000, 64'h1, 8'hFF, 2'd3);
        expect_req(56'h80003000, 64'h2, 8'hFF, 2'd3);
        drain(2, cyc);
    endtask

    task automatic test_full_wrap();
        int cyc;
        sb.stall_st_pending_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(56'h80004000 + 56'(i * 8), 64'h1000 + 64'(i), 8'hFF, 2'd3);
            commit_one();
            expect_req(56'h80004000 + 56'(i * 8), 64'h1000 + 64'(i), 8'hFF, 2'd3);
            if (i == 6) begin
                #1;
                n_checks++; if (sb.commit_ready_o !== 1'b1) $display("FAIL full_minus_one: commit_ready got %b expected 1", sb.commit_ready_o); else n_pass++;
            end
        end
        sb.page_offset_i = 12'h038;
        #1;
        n_checks++; if (sb.commit_ready_o !== 1'b0) $display("FAIL full_commit_ready: got %b expected 0", sb.commit_ready_o); else n_pass++;
        n_checks++; if (sb.page_offset_matches_o !== 1'b1) $display("FAIL full_page_match: got %b expected 1", sb.page_offset_matches_o); else n_pass++;
        sb.page_offset_i = 12'hFF8;
        #1;
        n_checks++; if (sb.page_offset_matches_o !== 1'b0) $display("FAIL page_nomatch: got %b expected 0", sb.page_offset_matches_o); else n_pass++;
        sb.valid_without_flush_i = 1'b1; sb.paddr_i = 56'h80009FF8;
        #1;
        n_checks++; if (sb.page_offset_matches_o !== 1'b1) $display("FAIL page_vwf_match: got %b expected 1", sb.page_offset_matches_o); else n_pass++;
        sb.valid_without_flush_i = 1'b0;
        drain(8, cyc);
        n_checks++; if (cyc !== 8) $display("FAIL back_to_back: took %0d cycles expected 8", cyc); else n_pass++;
        push(56'h80004100, 64'h77, 8'hFF, 2'd3);
        commit_one();
        expect_req(56'h80004100, 64'h77, 8'hFF, 2'd3);
        drain(1, cyc);
    endtask

    task automatic test_flush();
        int cyc;
        sb.stall_st_pending_i = 1'b1;
        push(56'h80005000, 64'h51, 8'hFF, 2'd3); commit_one();
        push(56'h80005008, 64'h52, 8'hFF, 2'd3); commit_one();
        expect_req(56'h80005000, 64'h51, 8'hFF, 2'd3);
        expect_req(56'h80005008, 64'h52, 8'hFF, 2'd3);
        push(56'h80006000, 64'h61, 8'hFF, 2'd3);
        push(56'h80006008, 64'h62, 8'hFF, 2'd3);
        push(56'h80006010, 64'h63, 8'hFF, 2'd3);
        #1;
        n_checks++; if (sb.ready_o !== 1'b0) $display("FAIL spec_full_ready: got %b expected 0", sb.ready_o); else n_pass++;
        sb.flush_i = 1'b1;
        sb.valid_i = 1'b1; sb.paddr_i = 56'h80006018; sb.data_i = 64'h64; sb.be_i = 8'hFF;
        tick();
        sb.flush_i = 1'b0; sb.valid_i = 1'b0;
        sb.fwd_paddr_i = 56'h80006000; sb.fwd_be_i = 8'hFF; sb.fwd_valid_i = 1'b1;
        #1;
        n_checks++; if (sb.ready_o !== 1'b1) $display("FAIL flush_ready: got %b expected 1", sb.ready_o); else n_pass++;
        n_checks++; if (sb.no_st_pending_o !== 1'b0) $display("FAIL flush_commit_kept: no_st_pending got %b expected 0", sb.no_st_pending_o); else n_pass++;
        n_checks++; if (sb.fwd_hit_o !== 1'b0) $display("FAIL flush_fwd: got hit=%b expected 0", sb.fwd_hit_o); else n_pass++;
        sb.fwd_valid_i = 1'b0;
        drain(2, cyc);
        #1;
        n_checks++; if (sb.store_buffer_empty_o !== 1'b1) $display("FAIL flush_empty: got %b expected 1", sb.store_buffer_empty_o); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        sb.stall_st_pending_i = 1'b1;
        push(56'h80007000, 64'h71, 8'hFF, 2'd3);
        commit_one();
        sb.stall_st_pending_i = 1'b0;
        #1;
        n_checks++; if (sb.req_data_req_o !== 1'b1) $display("FAIL pre_reset_req: got %b expected 1", sb.req_data_req_o); else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (sb.req_data_req_o !== 1'b0) $display("FAIL mid_reset_req: got %b expected 0", sb.req_data_req_o); else n_pass++;
        n_checks++; if (sb.store_buffer_empty_o !== 1'b1) $display("FAIL mid_reset_empty: got %b expected 1", sb.store_buffer_empty_o); else n_pass++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_push_commit_drain();
        test_coalesce();
        test_forwarding();
        test_youngest();
        test_full_wrap();
        test_flush();
        test_reset_mid_drain();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover: %0d expected requests never seen", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
